// File: rtl/mole_spawner.sv
// mole_spawner: LFSR-placed moles with fixed lifetime, hit/miss tallies and run control.
// Optional feature macro MOLE_MISS_LIMIT_EN: end the game once misses reach MAX_MISSES.
module mole_spawner #(
  parameter int          N_MOLES      = 18,
  parameter int          SPAWN_PERIOD = 50,
  parameter int          MOLE_LIFE    = 100,
  parameter int          MAX_ACTIVE   = 4,
  parameter int          MAX_MISSES   = 5,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_MOLES-1:0] hit_reg,
  output logic [N_MOLES-1:0] moles,
  output logic               running,
  output logic [7:0]         hits,
  output logic [7:0]         misses,
  output logic               game_over
);
  // state | meaning
  // IDLE  | waiting for start, moles held low
  // RUN   | spawning, aging and scoring moles
  // OVER  | miss limit reached, tallies frozen until start

  localparam int AW = (MOLE_LIFE > 1) ? $clog2(MOLE_LIFE) : 1;
  localparam int SW = $clog2(SPAWN_PERIOD);
  localparam int IW = $clog2(N_MOLES);
  localparam int CW = $clog2(N_MOLES + 1);
`ifdef MOLE_MISS_LIMIT_EN
  localparam bit MISS_LIMIT = 1'b1;
`else
  localparam bit MISS_LIMIT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t             state, state_nxt;
  logic [15:0]        lfsr, lfsr_adv;
  logic [SW-1:0]      spawn_cnt;
  logic [AW-1:0]      age [N_MOLES];
  logic [N_MOLES-1:0] hit_vec, exp_vec, moles_run;
  logic [CW-1:0]      n_raised;
  logic [IW-1:0]      cand;
  logic               spawn_tc, spawn_ok, miss_stop;
  logic [8:0]         hit_sum, miss_sum;
  logic [7:0]         hits_nxt, misses_nxt;

  function automatic logic [CW-1:0] popcnt(input logic [N_MOLES-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < N_MOLES; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  // Spawn decisions look only at the pre-update pattern, so dying moles still block.
  always_comb begin
    hit_vec = hit_reg & moles;
    exp_vec = '0;
    for (int i = 0; i < N_MOLES; i++)
      exp_vec[i] = moles[i] & ~hit_reg[i] & (age[i] == AW'(MOLE_LIFE - 1));
    n_raised  = popcnt(moles);
    cand      = IW'(lfsr % 16'(N_MOLES));
    spawn_tc  = (spawn_cnt == SW'(SPAWN_PERIOD - 1));
    spawn_ok  = spawn_tc && !moles[cand] && (n_raised < CW'(MAX_ACTIVE));
    moles_run = moles & ~hit_vec & ~exp_vec;
    if (spawn_ok) moles_run[cand] = 1'b1;
    hit_sum    = {1'b0, hits} + 9'(popcnt(hit_vec));
    miss_sum   = {1'b0, misses} + 9'(popcnt(exp_vec));
    hits_nxt   = hit_sum[8] ? 8'hFF : hit_sum[7:0];
    misses_nxt = miss_sum[8] ? 8'hFF : miss_sum[7:0];
    miss_stop  = MISS_LIMIT && (misses_nxt >= 8'(MAX_MISSES));
    lfsr_adv   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (miss_stop) state_nxt = OVER;
      OVER:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    running = (state == RUN);
`ifdef MOLE_MISS_LIMIT_EN
    game_over = (state == OVER);
`else
    game_over = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= SEED;
      moles     <= '0;
      hits      <= '0;
      misses    <= '0;
      spawn_cnt <= '0;
      for (int i = 0; i < N_MOLES; i++) age[i] <= '0;
    end else if (state == RUN) begin
      moles     <= miss_stop ? '0 : moles_run;
      hits      <= hits_nxt;
      misses    <= misses_nxt;
      lfsr      <= lfsr_adv;
      spawn_cnt <= spawn_tc ? '0 : spawn_cnt + SW'(1);
      for (int i = 0; i < N_MOLES; i++) begin
        if (spawn_ok && (cand == IW'(i))) age[i] <= '0;
        else if (moles[i])                age[i] <= age[i] + AW'(1);
      end
    end else begin
      moles <= '0;
      if (start) begin
        hits      <= '0;
        misses    <= '0;
        spawn_cnt <= '0;
        lfsr      <= SEED;
        for (int i = 0; i < N_MOLES; i++) age[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mole_spawner.sv
// Randomized scoreboard bench for mole_spawner against a deadline-based game model.
// Honours MOLE_MISS_LIMIT_EN the same way the design does.
module tb_mole_spawner;
  localparam int          N   = 18;
  localparam int          SP  = 4;
  localparam int          ML  = 6;
  localparam int          MA  = 2;
  localparam int          MM  = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic         clk, rst_n, start;
  logic [N-1:0] hit_reg, moles;
  logic         running, game_over;
  logic [7:0]   hits, misses;

  mole_spawner #(
    .N_MOLES(N), .SPAWN_PERIOD(SP), .MOLE_LIFE(ML),
    .MAX_ACTIVE(MA), .MAX_MISSES(MM), .SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit_reg(hit_reg),
    .moles(moles), .running(running), .hits(hits), .misses(misses),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] moles;
    logic         running;
    logic [7:0]   hits;
    logic [7:0]   misses;
    logic         game_over;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Model: each raised mole carries the run-edge number at which it will drop.
  localparam int M_IDLE = 0, M_RUN = 1, M_OVER = 2;
  int          m_state;
  bit          m_up   [N];
  int          m_dead [N];
  int          m_rc;
  int          m_hits, m_misses;
  logic [15:0] m_lfsr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  function automatic void model_reset();
    m_state = M_IDLE;
    for (int i = 0; i < N; i++) begin m_up[i] = 0; m_dead[i] = 0; end
    m_rc = 0; m_hits = 0; m_misses = 0; m_lfsr = SEED;
  endfunction

  function automatic void model_step(input bit st, input logic [N-1:0] hr);
    int  nh, nm, live, c;
    bit  spawn;
    nh = 0; nm = 0; live = 0;
    if (m_state != M_RUN) begin
      if (st) begin
        m_state = M_RUN;
        for (int i = 0; i < N; i++) m_up[i] = 0;
        m_rc = 0; m_hits = 0; m_misses = 0; m_lfsr = SEED;
      end
    end else begin
      m_rc++;
      for (int i = 0; i < N; i++) if (m_up[i]) live++;
      c = int'(m_lfsr % 16'd18);
      spawn = ((m_rc % SP) == 0) && !m_up[c] && (live < MA);
      for (int i = 0; i < N; i++) begin
        if (m_up[i]) begin
          if (hr[i]) begin nh++; m_up[i] = 0; end
          else if (m_dead[i] == m_rc) begin nm++; m_up[i] = 0; end
        end
      end
      if (spawn) begin m_up[c] = 1; m_dead[c] = m_rc + ML; end
      m_hits   = (m_hits + nh > 255) ? 255 : m_hits + nh;
      m_misses = (m_misses + nm > 255) ? 255 : m_misses + nm;
      m_lfsr   = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
`ifdef MOLE_MISS_LIMIT_EN
      if (m_misses >= MM) begin
        m_state = M_OVER;
        for (int i = 0; i < N; i++) m_up[i] = 0;
      end
`endif
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < N; i++) e.moles[i] = m_up[i];
    e.running   = (m_state == M_RUN);
    e.hits      = 8'(m_hits);
    e.misses    = 8'(m_misses);
    e.game_over = (m_state == M_OVER);
    return e;
  endfunction

  // Hits favour raised moles, especially on their last lifetime cycle; stray hits hit lowered ones.
  function automatic logic [N-1:0] pick_hits();
    logic [N-1:0] hr;
    for (int i = 0; i < N; i++) begin
      if (m_state == M_RUN && m_up[i]) begin
        if (m_dead[i] == m_rc + 1) hr[i] = 1'($urandom_range(0, 1));
        else                       hr[i] = ($urandom_range(0, 7) == 0);
      end else begin
        hr[i] = ($urandom_range(0, 39) == 0);
      end
    end
    return hr;
  endfunction

  task automatic drive_cycle(input bit st, input logic [N-1:0] hr);
    @(negedge clk);
    start   = st;
    hit_reg = hr;
    model_step(st, hr);
    exp_q.push_back(model_out());
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_moles"},   32'(moles), 32'd0);
    check({tag, "_running"}, 32'(running), 32'd0);
    check({tag, "_hits"},    32'(hits), 32'd0);
    check({tag, "_misses"},  32'(misses), 32'd0);
    check({tag, "_gover"},   32'(game_over), 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("moles",     32'(moles),     32'(e.moles));
        check("running",   32'(running),   32'(e.running));
        check("hits",      32'(hits),      32'(e.hits));
        check("misses",    32'(misses),    32'(e.misses));
        check("game_over", 32'(game_over), 32'(e.game_over));
      end
    end
  end

  initial begin : stim
    rst_n = 1'b1; start = 1'b0; hit_reg = '0;
    model_reset();
    #12 rst_n = 1'b0;
    #1 check_zero_outputs("reset");
    #20;
    @(negedge clk) rst_n = 1'b1;

    repeat (100) drive_cycle(1'b0, '0);

    drive_cycle(1'b1, '0);
    repeat (1200) drive_cycle(($urandom_range(0, 15) == 0), pick_hits());

    // Asynchronous reset mid-game, then a replay from the seed.
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_zero_outputs("midreset");
    @(negedge clk) rst_n = 1'b1;
    drive_cycle(1'b1, '0);
    repeat (300) drive_cycle(1'b0, pick_hits());

    // No hits at all: misses climb to saturation or the game ends and restarts.
    repeat (2600) drive_cycle(1'b1, '0);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
